bus_resync_tx: RTL and testbench

Source-domain end of a toggle req/ack bus crossing. Runs on the sending clock only. Accepts words over a valid/ready interface and drives a bus word held stable to the far domain. Signals each new word by toggling `req_tgl`, and retires it when the far domain's `ack_tgl` toggle is seen after synchronisation. A one-deep pending register lets upstream hand over the next word while the current one is still in flight.

---
 rtl/bus_resync_tx_pend.sv | 28 ++
 rtl/dff_resync.sv | 24 ++
 rtl/bus_resync_tx.sv | 112 +++++++++++
 tb/tb_bus_resync_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_resync_tx_pend.sv
// One-deep holding register that parks the next word while the
// current one is still waiting for the far-side acknowledge.
module bus_resync_tx_pend #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         clear,
    output logic [N-1:0] data,
    output logic         valid
);

    // load and clear never coincide: upstream is held off while valid is set
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dff_resync.sv
// Multi-flop synchroniser for a single asynchronous level or toggle.
// Depth must be at least 2 for metastability settling.
module dff_resync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/bus_resync_tx.sv
// Source-domain end of a toggle req/ack bus crossing: launches words with a
// request toggle and retires them on the synchronised acknowledge toggle.
module bus_resync_tx #(
    parameter int N      = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     bus_data,
    output logic             req_tgl,
    input  logic             ack_tgl,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             proto_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t         state;
    logic           out_q;
    logic           ack_s;
    logic           ack_prev;
    logic           ack_edge;
    logic           ack_done;
    logic           free;
    logic           pend_valid;
    logic [N-1:0]   pend_data;
    logic           launch_pend;
    logic           launch_in;
    logic           launch;
    logic           park;
    logic [N-1:0]   launch_data;

    dff_resync #(
        .STAGES (STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rstb (rstb),
        .d    (ack_tgl),
        .q    (ack_s)
    );

    assign out_q    = (state == WAIT_ACK);
    assign ack_edge = ack_s ^ ack_prev;
    assign ack_done = ack_edge & out_q;
    assign free     = ~out_q | ack_done;

    // A parked word always launches ahead of a fresh upstream word.
    assign launch_pend = free & pend_valid;
    assign launch_in   = free & ~pend_valid & in_valid;
    assign launch      = launch_pend | launch_in;
    assign launch_data = pend_valid ? pend_data : in_data;
    assign park        = in_valid & in_ready & ~free;

    assign in_ready = ~pend_valid;
    assign busy     = out_q | pend_valid;

    bus_resync_tx_pend #(
        .N (N)
    ) u_pend (
        .clk       (clk),
        .rstb      (rstb),
        .load      (park),
        .load_data (in_data),
        .clear     (launch_pend),
        .data      (pend_data),
        .valid     (pend_valid)
    );

    // Data and toggle move on the same edge; the receiver only samples
    // bus_data after its own synchronised view of the request edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            bus_data  <= '0;
            req_tgl   <= 1'b0;
            ack_prev  <= 1'b0;
            done      <= 1'b0;
            xfer_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            ack_prev <= ack_s;
            done     <= ack_done;
            if (ack_done) begin
                xfer_cnt <= xfer_cnt + CNT_ONE;
            end
            if (ack_edge && !out_q) begin
                proto_err <= 1'b1;
            end
            if (free) begin
                if (launch) begin
                    bus_data <= launch_data;
                    req_tgl  <= ~req_tgl;
                    state    <= WAIT_ACK;
                end else begin
                    state    <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_resync_tx.sv
// Self-checking bench for bus_resync_tx: scoreboard of launched words plus
// per-scenario timing checks against a toggle responder on ack_tgl.
module tb_bus_resync_tx;

    logic       clk;
    logic       rstb;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] bus_data;
    logic       req_tgl;
    logic       ack_tgl;
    logic       done;
    logic       busy;
    logic [7:0] xfer_cnt;
    logic       proto_err;

    int         pass_cnt;
    int         total_cnt;
    logic [7:0] exp_q[$];
    int         exp_cnt;
    int         done_count;
    int         relaunch_count;
    bit         mon_en;
    logic       mon_prev;
    bit         resp_en;
    int         resp_delay;
    int         resp_timer;
    logic       resp_prev;

    bus_resync_tx #(
        .N      (8),
        .STAGES (2),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bus_data  (bus_data),
        .req_tgl   (req_tgl),
        .ack_tgl   (ack_tgl),
        .done      (done),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge, then run the scoreboard and responder.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (done === 1'b1) done_count++;
        if (mon_en && req_tgl !== mon_prev) begin
            if (done === 1'b1) relaunch_count++;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL launch_order: unexpected launch bus_data=%h, nothing expected", bus_data);
            end else begin
                e = exp_q.pop_front();
                if (bus_data !== e) $display("[TB] FAIL launch_order: bus_data=%h want %h", bus_data, e);
                else pass_cnt++;
            end
        end
        mon_prev = req_tgl;
        if (resp_timer > 0) begin
            resp_timer--;
            if (resp_timer == 0) ack_tgl = ~ack_tgl;
        end else begin
            if (resp_en && req_tgl !== resp_prev) resp_timer = resp_delay;
            resp_prev = req_tgl;
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        int waited;
        in_data  = w;
        in_valid = 1'b1;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        if (in_ready !== 1'b1) begin
            total_cnt++;
            $display("[TB] FAIL send_timeout: in_ready=%b want 1 for word %h", in_ready, w);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(w);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        tick();
        while ((busy !== 1'b0 || exp_q.size() != 0) && waited < 500) begin
            tick();
            waited++;
        end
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            total_cnt++;
            $display("[TB] FAIL idle_timeout: busy=%b pending=%0d want 0/0", busy, exp_q.size());
        end
        tick();
    endtask

    task automatic test_reset();
        rstb       = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        ack_tgl    = 1'b0;
        mon_en     = 1'b0;
        resp_en    = 1'b0;
        resp_timer = 0;
        #12;
        total_cnt++; if (req_tgl !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", req_tgl); else pass_cnt++;
        total_cnt++; if (bus_data !== 8'h00) $display("[TB] FAIL reset_bus: got %h want 00", bus_data); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (xfer_cnt !== 8'h00) $display("[TB] FAIL reset_cnt: got %h want 00", xfer_cnt); else pass_cnt++;
        total_cnt++; if (proto_err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", proto_err); else pass_cnt++;
        tick();
        rstb = 1'b1;
        tick();
        mon_en  = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_single();
        resp_en  = 1'b0;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL single_ready: got %b want 1", in_ready); else pass_cnt++;
        exp_q.push_back(8'hA5);
        @(posedge clk);
        #1;
        total_cnt++; if (req_tgl !== 1'b1) $display("[TB] FAIL single_req: got %b want 1", req_tgl); else pass_cnt++;
        total_cnt++; if (bus_data !== 8'hA5) $display("[TB] FAIL single_bus: got %h want a5", bus_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b want 1", busy); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        ack_tgl = ~ack_tgl;
        tick();
        tick();
        total_cnt++; if (done !== 1'b0) $display("[TB] FAIL single_done_early: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (bus_data !== 8'hA5) $display("[TB] FAIL single_hold: got %h want a5", bus_data); else pass_cnt++;
        tick();
        exp_cnt = 1;
        total_cnt++; if (done !== 1'b1) $display("[TB] FAIL single_done: got %b want 1", done); else pass_cnt++;
        total_cnt++; if (xfer_cnt !== 8'(exp_cnt)) $display("[TB] FAIL single_cnt: got %h want %h", xfer_cnt, 8'(exp_cnt)); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_end: got %b want 0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("[TB] FAIL single_done_pulse: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int r0;
        r0         = relaunch_count;
        resp_en    = 1'b1;
        resp_delay = 4;
        send_word(8'h01);
        send_word(8'h02);
        total_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL b2b_pend_full: in_ready=%b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (bus_data !== 8'h01) $display("[TB] FAIL b2b_first: got %h want 01", bus_data); else pass_cnt++;
        send_word(8'h03);
        wait_idle();
        exp_cnt += 3;
        total_cnt++; if (xfer_cnt !== 8'(exp_cnt)) $display("[TB] FAIL b2b_cnt: got %h want %h", xfer_cnt, 8'(exp_cnt)); else pass_cnt++;
        total_cnt++; if (relaunch_count - r0 !== 2) $display("[TB] FAIL b2b_no_bubble: relaunches=%0d want 2", relaunch_count - r0); else pass_cnt++;
        total_cnt++; if (bus_data !== 8'h03) $display("[TB] FAIL b2b_last: got %h want 03", bus_data); else pass_cnt++;
        resp_en = 1'b0;
    endtask

    task automatic test_bypass();
        logic r;
        resp_en = 1'b0;
        send_word(8'h11);
        repeat (2) tick();
        ack_tgl = ~ack_tgl;
        tick();
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL bypass_ready: got %b want 1", in_ready); else pass_cnt++;
        r        = req_tgl;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        exp_q.push_back(8'h5A);
        @(posedge clk);
        #1;
        total_cnt++; if (req_tgl !== ~r) $display("[TB] FAIL bypass_req: got %b want %b", req_tgl, ~r); else pass_cnt++;
        total_cnt++; if (bus_data !== 8'h5A) $display("[TB] FAIL bypass_bus: got %h want 5a", bus_data); else pass_cnt++;
        total_cnt++; if (done !== 1'b1) $display("[TB] FAIL bypass_done: got %b want 1", done); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL bypass_pend_empty: in_ready=%b want 1", in_ready); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        ack_tgl  = ~ack_tgl;
        wait_idle();
        exp_cnt += 2;
        total_cnt++; if (xfer_cnt !== 8'(exp_cnt)) $display("[TB] FAIL bypass_cnt: got %h want %h", xfer_cnt, 8'(exp_cnt)); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int         d0;
        logic [7:0] w;
        test_reset();
        resp_en    = 1'b1;
        resp_delay = 1;
        d0         = done_count;
        for (int i = 0; i < 255; i++) begin
            w = 8'($urandom);
            send_word(w);
        end
        wait_idle();
        total_cnt++; if (xfer_cnt !== 8'hFF) $display("[TB] FAIL wrap_ff: got %h want ff", xfer_cnt); else pass_cnt++;
        send_word(8'hC3);
        wait_idle();
        exp_cnt = 0;
        total_cnt++; if (xfer_cnt !== 8'h00) $display("[TB] FAIL wrap_zero: got %h want 00", xfer_cnt); else pass_cnt++;
        total_cnt++; if (done_count - d0 !== 256) $display("[TB] FAIL wrap_done: pulses=%0d want 256", done_count - d0); else pass_cnt++;
        resp_en = 1'b0;
    endtask

    task automatic test_spurious();
        int d0;
        resp_en = 1'b0;
        d0      = done_count;
        ack_tgl = ~ack_tgl;
        tick();
        tick();
        total_cnt++; if (proto_err !== 1'b0) $display("[TB] FAIL spur_early: got %b want 0", proto_err); else pass_cnt++;
        tick();
        total_cnt++; if (proto_err !== 1'b1) $display("[TB] FAIL spur_err: got %b want 1", proto_err); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("[TB] FAIL spur_done: got %b want 0", done); else pass_cnt++;
        repeat (5) tick();
        total_cnt++; if (proto_err !== 1'b1) $display("[TB] FAIL spur_sticky: got %b want 1", proto_err); else pass_cnt++;
        total_cnt++; if (xfer_cnt !== 8'(exp_cnt)) $display("[TB] FAIL spur_cnt: got %h want %h", xfer_cnt, 8'(exp_cnt)); else pass_cnt++;
        total_cnt++; if (done_count !== d0) $display("[TB] FAIL spur_pulses: got %0d want %0d", done_count, d0); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        resp_en = 1'b0;
        send_word(8'h77);
        send_word(8'h88);
        total_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL mid_full: in_ready=%b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL mid_busy: got %b want 1", busy); else pass_cnt++;
        #2;
        mon_en = 1'b0;
        rstb   = 1'b0;
        #1;
        total_cnt++; if (req_tgl !== 1'b0) $display("[TB] FAIL mid_req: got %b want 0", req_tgl); else pass_cnt++;
        total_cnt++; if (bus_data !== 8'h00) $display("[TB] FAIL mid_bus: got %h want 00", bus_data); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy_rst: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (proto_err !== 1'b0) $display("[TB] FAIL mid_err: got %b want 0", proto_err); else pass_cnt++;
        total_cnt++; if (xfer_cnt !== 8'h00) $display("[TB] FAIL mid_cnt: got %h want 00", xfer_cnt); else pass_cnt++;
        exp_q.delete();
        ack_tgl    = 1'b0;
        resp_timer = 0;
        tick();
        tick();
        rstb = 1'b1;
        tick();
        mon_en     = 1'b1;
        exp_cnt    = 0;
        resp_en    = 1'b1;
        resp_delay = 4;
        send_word(8'h3C);
        total_cnt++; if (bus_data !== 8'h3C) $display("[TB] FAIL mid_relaunch: got %h want 3c", bus_data); else pass_cnt++;
        total_cnt++; if (req_tgl !== 1'b1) $display("[TB] FAIL mid_relaunch_req: got %b want 1", req_tgl); else pass_cnt++;
        wait_idle();
        exp_cnt = 1;
        total_cnt++; if (xfer_cnt !== 8'(exp_cnt)) $display("[TB] FAIL mid_after_cnt: got %h want %h", xfer_cnt, 8'(exp_cnt)); else pass_cnt++;
        total_cnt++; if (proto_err !== 1'b0) $display("[TB] FAIL mid_after_err: got %b want 0", proto_err); else pass_cnt++;
        resp_en = 1'b0;
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        done_count     = 0;
        relaunch_count = 0;
        mon_prev       = 1'b0;
        resp_prev      = 1'b0;
        resp_delay     = 4;
        test_reset();
        test_single();
        test_back_to_back();
        test_bypass();
        test_wrap();
        test_spurious();
        test_reset_midflight();
        repeat (3) tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
